// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared width helper and status bundle for fifo_thresh
package fifo_pkg;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic afull;
    logic aempty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

// File: rtl/fifo_thresh_if.sv
// rtl/fifo_thresh_if.sv - producer/consumer port bundle for fifo_thresh
interface fifo_thresh_if #(
  parameter int DATAW = 8,
  parameter int CNTW  = 3
);
  logic [DATAW-1:0] i_wr_data;
  logic             i_wr_en;
  logic             i_rd_en;
  logic             i_err_clr;
  logic [DATAW-1:0] o_rd_data;
  logic             o_rd_valid;
  logic             o_wr_full;
  logic             o_rd_empty;
  logic             o_afull;
  logic             o_aempty;
  logic [CNTW-1:0]  o_count;
  logic             o_overflow;
  logic             o_underflow;

  modport master (
    output i_wr_data, i_wr_en, i_rd_en, i_err_clr,
    input  o_rd_data, o_rd_valid, o_wr_full, o_rd_empty, o_afull, o_aempty,
           o_count, o_overflow, o_underflow
  );

  modport slave (
    input  i_wr_data, i_wr_en, i_rd_en, i_err_clr,
    output o_rd_data, o_rd_valid, o_wr_full, o_rd_empty, o_afull, o_aempty,
           o_count, o_overflow, o_underflow
  );
endinterface

// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - DEPTH x DATAW storage, synchronous write, combinational read
module fifo_ram #(
  parameter int DATAW = 8,
  parameter int DEPTH = 6,
  parameter int ADDRW = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ADDRW-1:0] waddr,
  input  logic [DATAW-1:0] wdata,
  input  logic [ADDRW-1:0] raddr,
  output logic [DATAW-1:0] rdata
);
  logic [DATAW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/fifo_thresh.sv
// rtl/fifo_thresh.sv - any-depth FIFO with count, thresholds and sticky errors
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is registered read.
module fifo_thresh
  import fifo_pkg::*;
#(
  parameter int DATAW      = 8,
  parameter int DEPTH      = 6,
  parameter int AFULL_THR  = DEPTH - 1,
  parameter int AEMPTY_THR = 1
) (
  input logic        clk,
  input logic        rst_n,
  fifo_thresh_if.slave bus
);
  localparam int CNTW  = cnt_width(DEPTH);
  localparam int ADDRW = $clog2(DEPTH);

  logic [ADDRW-1:0] wr_ptr, rd_ptr;
  logic [CNTW-1:0]  count, count_next;
  logic             empty, full;
  logic             rd_acc, wr_acc;
  logic             ovf, unf;
  logic [DATAW-1:0] ram_rdata;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [ADDRW-1:0] ptr_inc(input logic [ADDRW-1:0] p);
    return (p == ADDRW'(DEPTH - 1)) ? '0 : p + ADDRW'(1);
  endfunction

  assign empty  = (count == '0);
  assign full   = (count == CNTW'(DEPTH));
  assign rd_acc = bus.i_rd_en && !empty;
  assign wr_acc = bus.i_wr_en && (!full || rd_acc);

  always_comb begin
    count_next = count;
    case ({wr_acc, rd_acc})
      2'b10:   count_next = count + CNTW'(1);
      2'b01:   count_next = count - CNTW'(1);
      default: count_next = count;
    endcase
  end

  fifo_ram #(.DATAW(DATAW), .DEPTH(DEPTH), .ADDRW(ADDRW)) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (bus.i_wr_data),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
      count <= count_next;
    end
  end

  // A new error in the same cycle as the clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (bus.i_wr_en && !wr_acc) ovf <= 1'b1;
      else if (bus.i_err_clr)     ovf <= 1'b0;
      if (bus.i_rd_en && empty)   unf <= 1'b1;
      else if (bus.i_err_clr)     unf <= 1'b0;
    end
  end

`ifdef FIFO_FWFT_EN
  assign bus.o_rd_data  = empty ? '0 : ram_rdata;
  assign bus.o_rd_valid = !empty;
`else
  logic [DATAW-1:0] rd_data_q;
  logic             rd_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_acc;
      if (rd_acc) rd_data_q <= ram_rdata;
    end
  end

  assign bus.o_rd_data  = rd_data_q;
  assign bus.o_rd_valid = rd_valid_q;
`endif

  assign bus.o_count     = count;
  assign bus.o_wr_full   = full;
  assign bus.o_rd_empty  = empty;
  assign bus.o_afull     = (count >= CNTW'(AFULL_THR));
  assign bus.o_aempty    = (count <= CNTW'(AEMPTY_THR));
  assign bus.o_overflow  = ovf;
  assign bus.o_underflow = unf;
endmodule

// File: tb/tb_fifo_thresh.sv
// tb/tb_fifo_thresh.sv - directed vector bench for fifo_thresh (DEPTH=6, AFULL=5, AEMPTY=1)
module tb_fifo_thresh;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  fifo_thresh_if #(.DATAW(8), .CNTW(3)) bus ();

  fifo_thresh #(.DATAW(8), .DEPTH(6), .AFULL_THR(5), .AEMPTY_THR(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit       wr;
    bit       rd;
    bit       clr;
    bit [7:0] wdata;
    int       cnt;
    bit       full;
    bit       empty;
    bit       afull;
    bit       aempty;
    bit       ovf;
    bit       unf;
    bit       rv;
    bit [7:0] rdata;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.i_wr_en   = 1'b0;
    bus.i_rd_en   = 1'b0;
    bus.i_err_clr = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    bus.i_wr_en   = 1'b1;
    bus.i_wr_data = d;
    step();
    idle();
  endtask

  task automatic pop_check(input string name, input logic [7:0] exp);
`ifdef FIFO_FWFT_EN
    chk({name, "_valid"}, bus.o_rd_valid, 1);
    chk({name, "_data"}, bus.o_rd_data, exp);
    bus.i_rd_en = 1'b1;
    step();
    idle();
`else
    bus.i_rd_en = 1'b1;
    step();
    idle();
    chk({name, "_valid"}, bus.o_rd_valid, 1);
    chk({name, "_data"}, bus.o_rd_data, exp);
`endif
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, "_count"}, bus.o_count, 0);
    chk({name, "_empty"}, bus.o_rd_empty, 1);
    chk({name, "_full"}, bus.o_wr_full, 0);
    chk({name, "_aempty"}, bus.o_aempty, 1);
    chk({name, "_afull"}, bus.o_afull, 0);
    chk({name, "_ovf"}, bus.o_overflow, 0);
    chk({name, "_unf"}, bus.o_underflow, 0);
    chk({name, "_valid"}, bus.o_rd_valid, 0);
    chk({name, "_data"}, bus.o_rd_data, 0);
  endtask

  function automatic vec_t mk(bit wr, bit rd, bit clr, bit [7:0] wd, int cnt, bit full,
                              bit empty, bit af, bit ae, bit ovf, bit unf, bit rv, bit [7:0] rdat);
    vec_t v;
    v.wr = wr; v.rd = rd; v.clr = clr; v.wdata = wd;
    v.cnt = cnt; v.full = full; v.empty = empty; v.afull = af; v.aempty = ae;
    v.ovf = ovf; v.unf = unf; v.rv = rv; v.rdata = rdat;
    return v;
  endfunction

  initial begin
    logic [7:0] d;
    // wr rd clr wdata | cnt full empty afull aempty ovf unf rv rdata
    vecs.push_back(mk(1, 0, 0, 8'h01, 1, 0, 0, 0, 1, 0, 0, 0, 8'h00));
    vecs.push_back(mk(1, 0, 0, 8'h02, 2, 0, 0, 0, 0, 0, 0, 0, 8'h00));
    vecs.push_back(mk(1, 0, 0, 8'h03, 3, 0, 0, 0, 0, 0, 0, 0, 8'h00));
    vecs.push_back(mk(1, 0, 0, 8'h04, 4, 0, 0, 0, 0, 0, 0, 0, 8'h00));
    vecs.push_back(mk(1, 0, 0, 8'h05, 5, 0, 0, 1, 0, 0, 0, 0, 8'h00));
    vecs.push_back(mk(1, 0, 0, 8'h06, 6, 1, 0, 1, 0, 0, 0, 0, 8'h00));
    vecs.push_back(mk(1, 0, 0, 8'h07, 6, 1, 0, 1, 0, 1, 0, 0, 8'h00));
    vecs.push_back(mk(0, 0, 1, 8'h00, 6, 1, 0, 1, 0, 0, 0, 0, 8'h00));
    vecs.push_back(mk(1, 1, 0, 8'hAA, 6, 1, 0, 1, 0, 0, 0, 1, 8'h01));
    vecs.push_back(mk(0, 1, 0, 8'h00, 5, 0, 0, 1, 0, 0, 0, 1, 8'h02));
    vecs.push_back(mk(0, 1, 0, 8'h00, 4, 0, 0, 0, 0, 0, 0, 1, 8'h03));
    vecs.push_back(mk(0, 1, 0, 8'h00, 3, 0, 0, 0, 0, 0, 0, 1, 8'h04));
    vecs.push_back(mk(0, 1, 0, 8'h00, 2, 0, 0, 0, 0, 0, 0, 1, 8'h05));
    vecs.push_back(mk(0, 1, 0, 8'h00, 1, 0, 0, 0, 1, 0, 0, 1, 8'h06));
    vecs.push_back(mk(0, 1, 0, 8'h00, 0, 0, 1, 0, 1, 0, 0, 1, 8'hAA));
    vecs.push_back(mk(0, 1, 0, 8'h00, 0, 0, 1, 0, 1, 0, 1, 0, 8'hAA));
    vecs.push_back(mk(1, 1, 0, 8'h33, 1, 0, 0, 0, 1, 0, 1, 0, 8'hAA));
    vecs.push_back(mk(0, 1, 1, 8'h00, 0, 0, 1, 0, 1, 0, 0, 1, 8'h33));
    vecs.push_back(mk(0, 1, 1, 8'h00, 0, 0, 1, 0, 1, 0, 1, 0, 8'h33));
    vecs.push_back(mk(0, 0, 1, 8'h00, 0, 0, 1, 0, 1, 0, 0, 0, 8'h33));

    bus.i_wr_data = 8'h00;
    idle();
    step();
    step();
    chk_reset_vals("reset");
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      bus.i_wr_en   = vecs[i].wr;
      bus.i_rd_en   = vecs[i].rd;
      bus.i_err_clr = vecs[i].clr;
      bus.i_wr_data = vecs[i].wdata;
      step();
      idle();
      chk($sformatf("v%0d_count", i), bus.o_count, vecs[i].cnt);
      chk($sformatf("v%0d_full", i), bus.o_wr_full, vecs[i].full);
      chk($sformatf("v%0d_empty", i), bus.o_rd_empty, vecs[i].empty);
      chk($sformatf("v%0d_afull", i), bus.o_afull, vecs[i].afull);
      chk($sformatf("v%0d_aempty", i), bus.o_aempty, vecs[i].aempty);
      chk($sformatf("v%0d_ovf", i), bus.o_overflow, vecs[i].ovf);
      chk($sformatf("v%0d_unf", i), bus.o_underflow, vecs[i].unf);
`ifdef FIFO_FWFT_EN
      chk($sformatf("v%0d_valid", i), bus.o_rd_valid, !vecs[i].empty);
`else
      chk($sformatf("v%0d_valid", i), bus.o_rd_valid, vecs[i].rv);
      chk($sformatf("v%0d_data", i), bus.o_rd_data, vecs[i].rdata);
`endif
    end

    // Wrap-around: 20 entries through a 6-deep ring.
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 4; k++) begin
        d = 8'h40 + 8'(r * 4 + k);
        push(d);
      end
      chk($sformatf("wrap%0d_count", r), bus.o_count, 4);
      for (int k = 0; k < 4; k++) begin
        d = 8'h40 + 8'(r * 4 + k);
        pop_check($sformatf("wrap%0d_%0d", r, k), d);
      end
      chk($sformatf("wrap%0d_empty", r), bus.o_rd_empty, 1);
    end
    chk("wrap_ovf", bus.o_overflow, 0);
    chk("wrap_unf", bus.o_underflow, 0);

    // Asynchronous reset with three entries stored.
    push(8'h11);
    push(8'h22);
    push(8'h33);
    chk("pre_rst_count", bus.o_count, 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    step();
    rst_n = 1'b1;

    push(8'h5C);
    chk("post_rst_count", bus.o_count, 1);
    pop_check("post_rst_5c", 8'h5C);
    chk("post_rst_empty", bus.o_rd_empty, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
